// File: rtl/imem_uart_loader_if.sv
// Instruction memory write port driven by the UART loader.
interface imem_uart_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART frame receiver that writes a checksummed program image into the
// instruction memory and holds the pipeline in reset until it is verified.
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned TIMEOUT_CLKS = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    imem_uart_loader_if.master         imem,
    output logic                       cpu_hold,
    output logic                       load_done,
    output logic                       load_err
);
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned REM_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE} state_t;

    // receiver registers
    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             byte_vld, byte_vld_n;
    logic             frame_err, frame_err_n;

    // frame FSM registers
    state_t            state, state_n;
    logic [7:0]        len_lo, len_lo_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic [ADDR_W-1:0] widx, widx_n;
    logic [1:0]        lane, lane_n;
    logic [23:0]       sh, sh_n;
    logic [7:0]        xsum, xsum_n;
    logic [TMO_W-1:0]  tmo, tmo_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              hold_n, done_n, err_n;
    logic              in_frame_c, abort_c;
    logic [15:0]       len_c;

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;

    // Synchronizer and receiver state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= uart_rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_sh     <= rx_sh_n;
            rx_byte   <= rx_byte_n;
            byte_vld  <= byte_vld_n;
            frame_err <= frame_err_n;
        end
    end

    // Receiver next state: start-bit check at half bit, then bit-centre sampling
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        rx_byte_n   = rx_byte;
        byte_vld_n  = 1'b0;
        frame_err_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    // still high at mid start bit means it was a glitch
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s) begin
                        byte_vld_n = 1'b1;
                        rx_byte_n  = rx_sh;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Frame FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            rem       <= '0;
            widx      <= '0;
            lane      <= '0;
            sh        <= '0;
            xsum      <= '0;
            tmo       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_n;
            len_lo    <= len_lo_n;
            rem       <= rem_n;
            widx      <= widx_n;
            lane      <= lane_n;
            sh        <= sh_n;
            xsum      <= xsum_n;
            tmo       <= tmo_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            cpu_hold  <= hold_n;
            load_done <= done_n;
            load_err  <= err_n;
        end
    end

    // Frame parsing, word assembly, checksum, timeout and abort handling
    always_comb begin
        state_n  = state;
        len_lo_n = len_lo;
        rem_n    = rem;
        widx_n   = widx;
        lane_n   = lane;
        sh_n     = sh;
        xsum_n   = xsum;
        tmo_n    = tmo;
        we_n     = 1'b0;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        hold_n   = cpu_hold;
        done_n   = load_done;
        err_n    = load_err;
        abort_c  = 1'b0;
        len_c    = {rx_byte, len_lo};

        in_frame_c = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CHK);

        if (in_frame_c) begin
            tmo_n = byte_vld ? '0 : tmo + TMO_W'(1);
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (byte_vld && rx_byte == SYNC_BYTE) begin
                    state_n = S_LEN_LO;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    hold_n  = 1'b1;
                    widx_n  = '0;
                    lane_n  = '0;
                    xsum_n  = '0;
                    tmo_n   = '0;
                end
            end
            S_LEN_LO: begin
                if (byte_vld) begin
                    len_lo_n = rx_byte;
                    xsum_n   = xsum ^ rx_byte;
                    state_n  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_vld) begin
                    xsum_n = xsum ^ rx_byte;
                    if (32'(len_c) > MAX_WORDS) begin
                        abort_c = 1'b1;
                    end else if (len_c == 16'd0) begin
                        state_n = S_CHK;
                    end else begin
                        rem_n   = REM_W'(len_c);
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_vld) begin
                    xsum_n = xsum ^ rx_byte;
                    case (lane)
                        2'd0: sh_n[7:0]   = rx_byte;
                        2'd1: sh_n[15:8]  = rx_byte;
                        2'd2: sh_n[23:16] = rx_byte;
                        default: begin
                            we_n    = 1'b1;
                            addr_n  = widx;
                            wdata_n = {rx_byte, sh};
                            widx_n  = widx + ADDR_W'(1);
                            rem_n   = rem - REM_W'(1);
                            if (rem == REM_W'(1)) begin
                                state_n = S_CHK;
                            end
                        end
                    endcase
                    lane_n = lane + 2'd1;
                end
            end
            S_CHK: begin
                if (byte_vld) begin
                    if (rx_byte == xsum) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
                    end else begin
                        abort_c = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (in_frame_c && (frame_err ||
                (!byte_vld && tmo == TMO_W'(TIMEOUT_CLKS - 1)))) begin
            abort_c = 1'b1;
        end

        // abort keeps already-written words; pipeline stays held
        if (abort_c) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            done_n  = 1'b0;
            hold_n  = 1'b1;
            tmo_n   = '0;
        end
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes and status events are
// queued by the stimulus thread and checked by an independent monitor.
module tb_imem_uart_loader;
    localparam int unsigned CPB    = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TMO    = 100;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic cpu_hold, load_done, load_err;

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) imem ();

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .imem(imem.master),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    logic [2:0] st_q[$];      // {load_done, load_err, cpu_hold}
    logic [7:0] frame_q[$];
    logic done_d = 1'b0;
    logic err_d  = 1'b0;

    // Monitor: compares every write and every rising status flag with the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (imem.imem_we) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%08h", imem.imem_addr, imem.imem_wdata);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    if (imem.imem_addr !== e.addr || imem.imem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write got addr=%0h data=%08h expected addr=%0h data=%08h",
                                 imem.imem_addr, imem.imem_wdata, e.addr, e.data);
                    end
                end
            end
            if ((load_done && !done_d) || (load_err && !err_d)) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_status done/err/hold=%b", {load_done, load_err, cpu_hold});
                end else begin
                    logic [2:0] s;
                    s = st_q.pop_front();
                    if ({load_done, load_err, cpu_hold} !== s) begin
                        errors++;
                        $display("FAIL status got done/err/hold=%b expected %b",
                                 {load_done, load_err, cpu_hold}, s);
                    end
                end
            end
        end
        done_d = load_done;
        err_d  = load_err;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    endtask

    task automatic settle(input string name);
        repeat (30) @(negedge clk);
        check({name, "_writes_drained"}, 64'(wr_q.size()), 64'd0);
        check({name, "_status_drained"}, 64'(st_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string name);
        check(name, 64'({imem.imem_we, imem.imem_addr, imem.imem_wdata, cpu_hold, load_done, load_err}),
              64'({1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // two-word image with correct checksum
        wr_q.push_back('{addr: 10'd0, data: 32'h00500093});
        wr_q.push_back('{addr: 10'd1, data: 32'h00100113});
        st_q.push_back(3'b100);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                    8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
        send_frame();
        settle("good2");
        check("good2_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b100));

        // same image, bad checksum: writes happen, then abort
        wr_q.push_back('{addr: 10'd0, data: 32'h00500093});
        wr_q.push_back('{addr: 10'd1, data: 32'h00100113});
        st_q.push_back(3'b011);
        frame_q[11] = 8'hC4;
        send_frame();
        settle("badchk");
        check("badchk_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b011));

        // empty image
        st_q.push_back(3'b100);
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame();
        settle("empty");
        check("empty_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b100));

        // N = 1025 exceeds 1024-word memory
        st_q.push_back(3'b011);
        frame_q = '{8'hA5, 8'h01, 8'h04};
        send_frame();
        settle("oversize");
        check("oversize_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b011));

        // framing error mid-word, then a good one-word frame
        st_q.push_back(3'b011);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h93};
        send_frame();
        send_byte(8'h00, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        settle("framerr");
        check("framerr_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b011));
        wr_q.push_back('{addr: 10'd0, data: 32'h12345678});
        st_q.push_back(3'b100);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_frame();
        settle("recover");
        check("recover_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b100));

        // one-clock glitch must not produce a byte
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        settle("glitch");
        check("glitch_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b100));

        // stall after LEN_LO until the timeout fires
        st_q.push_back(3'b011);
        frame_q = '{8'hA5, 8'h01};
        send_frame();
        repeat (150) @(negedge clk);
        settle("timeout");
        check("timeout_levels", 64'({load_done, load_err, cpu_hold}), 64'(3'b011));

        // reset in the middle of the second word
        wr_q.push_back('{addr: 10'd0, data: 32'h00500093});
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        send_frame();
        uart_rx = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        rst     = 1'b1;
        uart_rx = 1'b1;
        #1;
        check_reset_values("midframe_reset");
        @(negedge clk);
        check_reset_values("midframe_reset_held");
        rst = 1'b0;
        settle("post_reset");

        // loader works again after reset
        st_q.push_back(3'b100);
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame();
        settle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
